// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, flush and RAM port bundle for mem_arbiter
interface mem_arbiter_if;
    logic        rdy;
    logic        in_if_flag;
    logic [31:0] in_if_pc;
    logic        out_if_flag;
    logic [31:0] out_if_inst;
    logic        in_ls_flag;
    logic        in_ls_wr;
    logic [31:0] in_ls_addr;
    logic [1:0]  in_ls_size;
    logic [31:0] in_ls_data;
    logic        out_ls_flag;
    logic [31:0] out_ls_data;
    logic        in_rob_xbp;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport slave (
        input  rdy, in_if_flag, in_if_pc, in_ls_flag, in_ls_wr, in_ls_addr, in_ls_size,
               in_ls_data, in_rob_xbp, io_buffer_full, mem_din,
        output out_if_flag, out_if_inst, out_ls_flag, out_ls_data, mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy, in_if_flag, in_if_pc, in_ls_flag, in_ls_wr, in_ls_addr, in_ls_size,
               in_ls_data, in_rob_xbp, io_buffer_full, mem_din,
        input  out_if_flag, out_if_inst, out_ls_flag, out_ls_data, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/load-store arbiter onto a byte-wide RAM port
module mem_arbiter #(
    parameter logic [1:0] IO_HI_ADDR = 2'b11
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

    state_t      state, state_n;
    logic        pend_if, pend_if_n, pend_ls, pend_ls_n, last_ls, last_ls_n;
    logic [31:0] if_pc, if_pc_n, ls_addr, ls_addr_n, ls_data, ls_data_n;
    logic        ls_wr, ls_wr_n;
    logic [1:0]  ls_size, ls_size_n;
    logic [1:0]  cnt, cnt_n, last, last_n;
    logic [31:0] base, base_n, wdata, wdata_n, acc, acc_n;
    logic        out_if_flag, out_if_flag_n, out_ls_flag, out_ls_flag_n;
    logic [31:0] out_if_inst, out_if_inst_n, out_ls_data, out_ls_data_n;
    logic [7:0]  mem_dout, mem_dout_n;
    logic [31:0] mem_a, mem_a_n;
    logic        mem_wr_q, mem_wr_n;
    logic        flush, pif, pls, pick_ls;
    logic [1:0]  cnt_p1;
    logic [31:0] next_a, asm_w;

    function automatic logic io_stall(input logic [1:0] hi, input logic full);
        return (hi == IO_HI_ADDR) && full;
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    assign flush           = bus.in_rob_xbp;
    assign bus.out_if_flag = out_if_flag;
    assign bus.out_if_inst = out_if_inst;
    assign bus.out_ls_flag = out_ls_flag;
    assign bus.out_ls_data = out_ls_data;
    assign bus.mem_dout    = mem_dout;
    assign bus.mem_a       = mem_a;
    assign bus.mem_wr      = mem_wr_q & bus.rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pend_if     <= 1'b0;
            pend_ls     <= 1'b0;
            last_ls     <= 1'b0;
            if_pc       <= '0;
            ls_addr     <= '0;
            ls_data     <= '0;
            ls_wr       <= 1'b0;
            ls_size     <= '0;
            cnt         <= '0;
            last        <= '0;
            base        <= '0;
            wdata       <= '0;
            acc         <= '0;
            out_if_flag <= 1'b0;
            out_ls_flag <= 1'b0;
            out_if_inst <= '0;
            out_ls_data <= '0;
            mem_dout    <= '0;
            mem_a       <= '0;
            mem_wr_q    <= 1'b0;
        end else if (bus.rdy) begin
            state       <= state_n;
            pend_if     <= pend_if_n;
            pend_ls     <= pend_ls_n;
            last_ls     <= last_ls_n;
            if_pc       <= if_pc_n;
            ls_addr     <= ls_addr_n;
            ls_data     <= ls_data_n;
            ls_wr       <= ls_wr_n;
            ls_size     <= ls_size_n;
            cnt         <= cnt_n;
            last        <= last_n;
            base        <= base_n;
            wdata       <= wdata_n;
            acc         <= acc_n;
            out_if_flag <= out_if_flag_n;
            out_ls_flag <= out_ls_flag_n;
            out_if_inst <= out_if_inst_n;
            out_ls_data <= out_ls_data_n;
            mem_dout    <= mem_dout_n;
            mem_a       <= mem_a_n;
            mem_wr_q    <= mem_wr_n;
        end
    end

    always_comb begin
        state_n       = state;
        pend_if_n     = pend_if;
        pend_ls_n     = pend_ls;
        last_ls_n     = last_ls;
        if_pc_n       = if_pc;
        ls_addr_n     = ls_addr;
        ls_data_n     = ls_data;
        ls_wr_n       = ls_wr;
        ls_size_n     = ls_size;
        cnt_n         = cnt;
        last_n        = last;
        base_n        = base;
        wdata_n       = wdata;
        acc_n         = acc;
        out_if_flag_n = 1'b0;
        out_ls_flag_n = 1'b0;
        out_if_inst_n = out_if_inst;
        out_ls_data_n = out_ls_data;
        mem_dout_n    = mem_dout;
        mem_a_n       = mem_a;
        mem_wr_n      = 1'b0;
        pick_ls       = 1'b0;
        cnt_p1        = cnt + 2'd1;
        next_a        = base + {30'd0, cnt_p1};
        asm_w         = acc;
        asm_w[{cnt, 3'b000} +: 8] = bus.mem_din;

        // Speculative traffic dies on a flush; committed stores survive it.
        pif = pend_if & ~flush;
        pls = pend_ls & ~(flush & ~ls_wr);
        if (flush) begin
            pend_if_n = 1'b0;
            if (!ls_wr) pend_ls_n = 1'b0;
        end

        case (state)
            IDLE: begin
                pick_ls = pls & (~pif | ~last_ls);
                if (pick_ls) begin
                    pend_ls_n  = 1'b0;
                    last_ls_n  = 1'b1;
                    base_n     = ls_addr;
                    mem_a_n    = ls_addr;
                    cnt_n      = 2'd0;
                    last_n     = last_idx(ls_size);
                    acc_n      = '0;
                    wdata_n    = ls_data;
                    mem_dout_n = ls_data[7:0];
                    if (ls_wr) begin
                        state_n  = LS_WR;
                        mem_wr_n = !io_stall(ls_addr[17:16], bus.io_buffer_full);
                    end else begin
                        state_n  = LS_RD;
                    end
                end else if (pif) begin
                    pend_if_n = 1'b0;
                    last_ls_n = 1'b0;
                    base_n    = if_pc;
                    mem_a_n   = if_pc;
                    cnt_n     = 2'd0;
                    last_n    = 2'd3;
                    acc_n     = '0;
                    state_n   = IF_RD;
                end
            end
            IF_RD, LS_RD: begin
                if (flush) begin
                    state_n = IDLE;
                end else if (cnt == last) begin
                    state_n = IDLE;
                    if (state == IF_RD) begin
                        out_if_flag_n = 1'b1;
                        out_if_inst_n = asm_w;
                    end else begin
                        out_ls_flag_n = 1'b1;
                        out_ls_data_n = asm_w;
                    end
                end else begin
                    acc_n   = asm_w;
                    cnt_n   = cnt_p1;
                    mem_a_n = next_a;
                end
            end
            LS_WR: begin
                // mem_wr_q low here means the byte at cnt is still held by the I/O stall.
                if (mem_wr_q) begin
                    if (cnt == last) begin
                        state_n       = IDLE;
                        out_ls_flag_n = 1'b1;
                    end else begin
                        cnt_n      = cnt_p1;
                        mem_a_n    = next_a;
                        mem_dout_n = wdata[{cnt_p1, 3'b000} +: 8];
                        mem_wr_n   = !io_stall(next_a[17:16], bus.io_buffer_full);
                    end
                end else begin
                    mem_wr_n = !io_stall(mem_a[17:16], bus.io_buffer_full);
                end
            end
            default: state_n = IDLE;
        endcase

        if (bus.in_if_flag && !flush) begin
            pend_if_n = 1'b1;
            if_pc_n   = bus.in_if_pc;
        end
        if (bus.in_ls_flag && !(flush && !bus.in_ls_wr)) begin
            pend_ls_n = 1'b1;
            ls_wr_n   = bus.in_ls_wr;
            ls_addr_n = bus.in_ls_addr;
            ls_size_n = bus.in_ls_size;
            ls_data_n = bus.in_ls_data;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a byte RAM model
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   wr_count = 0;

    typedef struct {
        bit          is_ls;
        bit          chk_data;
        logic [31:0] data;
        int          at;
    } resp_t;
    resp_t exp_q[$];

    logic [7:0] ram   [0:262143];
    bit         wrote [0:262143];

    mem_arbiter_if bus();
    mem_arbiter #(.IO_HI_ADDR(2'b11)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input logic [17:0] a);
        case (a)
            18'h01000: return 8'h13;
            18'h01001: return 8'h05;
            18'h00000: return 8'h93;
            18'h00002: return 8'h10;
            18'h02000: return 8'h78;
            18'h02001: return 8'h56;
            18'h02002: return 8'h34;
            18'h02003: return 8'h12;
            default:   return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ram_byte(input logic [17:0] a);
        return wrote[a] ? ram[a] : init_byte(a);
    endfunction

    always_comb bus.mem_din = ram_byte(bus.mem_a[17:0]);

    always @(posedge clk) begin
        if (bus.mem_wr) begin
            ram[bus.mem_a[17:0]]   <= bus.mem_dout;
            wrote[bus.mem_a[17:0]] <= 1'b1;
            wr_count               <= wr_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_done(input bit is_ls, input bit cd, input logic [31:0] d, input int at);
        resp_t r;
        r.is_ls = is_ls; r.chk_data = cd; r.data = d; r.at = at;
        exp_q.push_back(r);
    endtask

    task automatic pulse_if(input logic [31:0] pc);
        bus.in_if_flag = 1'b1; bus.in_if_pc = pc;
        tick();
        bus.in_if_flag = 1'b0;
    endtask

    task automatic pulse_ls(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] d);
        bus.in_ls_flag = 1'b1; bus.in_ls_wr = wr; bus.in_ls_addr = a;
        bus.in_ls_size = sz; bus.in_ls_data = d;
        tick();
        bus.in_ls_flag = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        tick(); tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_if_flag"}, 32'(bus.out_if_flag), 32'd0);
        chk({tag, "_out_ls_flag"}, 32'(bus.out_ls_flag), 32'd0);
        chk({tag, "_out_if_inst"}, bus.out_if_inst, 32'd0);
        chk({tag, "_out_ls_data"}, bus.out_ls_data, 32'd0);
        chk({tag, "_mem_dout"},    32'(bus.mem_dout), 32'd0);
        chk({tag, "_mem_a"},       bus.mem_a, 32'd0);
        chk({tag, "_mem_wr"},      32'(bus.mem_wr), 32'd0);
    endtask

    initial begin
        int c;
        int w0;
        bus.rdy = 1'b1; bus.in_if_flag = 1'b0; bus.in_if_pc = '0;
        bus.in_ls_flag = 1'b0; bus.in_ls_wr = 1'b0; bus.in_ls_addr = '0;
        bus.in_ls_size = '0; bus.in_ls_data = '0; bus.in_rob_xbp = 1'b0;
        bus.io_buffer_full = 1'b0;

        fork
            begin : monitor
                resp_t r;
                forever begin
                    @(negedge clk);
                    if (!rst && (bus.out_if_flag || bus.out_ls_flag)) begin
                        chk("one_flag", 32'(bus.out_if_flag & bus.out_ls_flag), 32'd0);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_done", 32'd1, 32'd0);
                        end else begin
                            r = exp_q.pop_front();
                            chk("done_kind", 32'(bus.out_ls_flag), 32'(r.is_ls));
                            chk("done_cycle", 32'(cyc), 32'(r.at));
                            if (r.chk_data)
                                chk("done_data", bus.out_ls_flag ? bus.out_ls_data : bus.out_if_inst,
                                    r.data);
                        end
                    end
                end
            end
        join_none

        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Fetch of 0x1000: bytes walk out on mem_a, instruction 0x00000513 four cycles after grant.
        c = cyc;
        expect_done(1'b0, 1'b1, 32'h00000513, c + 6);
        pulse_if(32'h1000);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fetch_mem_a", bus.mem_a, 32'h1000 + 32'(i));
            chk("fetch_mem_wr", 32'(bus.mem_wr), 32'd0);
        end
        drain(40);

        // Same-cycle requests after reset: LS first, IF five cycles later.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        c = cyc;
        expect_done(1'b1, 1'b1, 32'h12345678, c + 6);
        expect_done(1'b0, 1'b1, 32'h00100093, c + 11);
        bus.in_if_flag = 1'b1; bus.in_if_pc = 32'h0;
        bus.in_ls_flag = 1'b1; bus.in_ls_wr = 1'b0; bus.in_ls_addr = 32'h2000; bus.in_ls_size = 2'b10;
        tick();
        bus.in_if_flag = 1'b0; bus.in_ls_flag = 1'b0;
        drain(40);

        // I/O store stalled by a full UART buffer for three cycles.
        w0 = wr_count;
        c = cyc;
        expect_done(1'b1, 1'b0, 32'h0, c + 6);
        pulse_ls(1'b1, 32'h30000, 2'b00, 32'h000000AB);
        bus.io_buffer_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("io_stall_mem_wr", 32'(bus.mem_wr), 32'd0);
            chk("io_stall_mem_a", bus.mem_a, 32'h30000);
        end
        bus.io_buffer_full = 1'b0;
        tick();
        chk("io_write_mem_wr", 32'(bus.mem_wr), 32'd1);
        chk("io_write_dout", 32'(bus.mem_dout), 32'h000000AB);
        drain(40);
        chk("io_write_count", 32'(wr_count - w0), 32'd1);
        chk("io_ram_byte", 32'(ram_byte(18'h30000)), 32'h000000AB);

        // Flush at cnt=2 of a fetch; a fetch pulsed on the flush cycle is dropped.
        c = cyc;
        pulse_if(32'h1000);
        tick(); tick(); tick();
        bus.in_rob_xbp = 1'b1; bus.in_if_flag = 1'b1; bus.in_if_pc = 32'h2000;
        tick();
        bus.in_rob_xbp = 1'b0; bus.in_if_pc = 32'h0;
        chk("flush_no_flag", 32'(bus.out_if_flag), 32'd0);
        chk("flush_mem_wr", 32'(bus.mem_wr), 32'd0);
        expect_done(1'b0, 1'b1, 32'h00100093, cyc + 6);
        tick();
        bus.in_if_flag = 1'b0;
        drain(40);

        // Halfword store then load at 0x100.
        w0 = wr_count;
        c = cyc;
        expect_done(1'b1, 1'b0, 32'h0, c + 4);
        pulse_ls(1'b1, 32'h100, 2'b01, 32'h0000BEEF);
        tick();
        chk("sh_b0_wr", 32'(bus.mem_wr), 32'd1);
        chk("sh_b0_a", bus.mem_a, 32'h100);
        chk("sh_b0_d", 32'(bus.mem_dout), 32'h000000EF);
        tick();
        chk("sh_b1_a", bus.mem_a, 32'h101);
        chk("sh_b1_d", 32'(bus.mem_dout), 32'h000000BE);
        drain(40);
        chk("sh_write_count", 32'(wr_count - w0), 32'd2);
        c = cyc;
        expect_done(1'b1, 1'b1, 32'h0000BEEF, c + 4);
        pulse_ls(1'b0, 32'h100, 2'b01, 32'hFFFFFFFF);
        drain(40);

        // Asynchronous reset in the middle of a word store.
        pulse_ls(1'b1, 32'h200, 2'b10, 32'hCAFEF00D);
        tick(); tick();
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        tick(); tick();
        rst = 1'b0;
        tick();

        // rdy low for five cycles mid-fetch freezes mem_a and stretches the latency.
        c = cyc;
        expect_done(1'b0, 1'b1, 32'h00000513, c + 11);
        pulse_if(32'h1000);
        tick(); tick();
        chk("frz_pre_a", bus.mem_a, 32'h1001);
        bus.rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("frz_mem_a", bus.mem_a, 32'h1001);
        end
        bus.rdy = 1'b1;
        drain(40);

        // rdy low mid-store masks mem_wr and holds the byte.
        w0 = wr_count;
        c = cyc;
        expect_done(1'b1, 1'b0, 32'h0, c + 8);
        pulse_ls(1'b1, 32'h300, 2'b10, 32'h11223344);
        tick(); tick();
        chk("sw_frz_pre_d", 32'(bus.mem_dout), 32'h00000033);
        bus.rdy = 1'b0;
        #1 chk("sw_frz_mem_wr", 32'(bus.mem_wr), 32'd0);
        tick();
        chk("sw_frz_a0", bus.mem_a, 32'h301);
        tick();
        chk("sw_frz_a1", bus.mem_a, 32'h301);
        bus.rdy = 1'b1;
        drain(40);
        chk("sw_write_count", 32'(wr_count - w0), 32'd4);
        chk("sw_ram_word", {ram_byte(18'h303), ram_byte(18'h302), ram_byte(18'h301), ram_byte(18'h300)},
            32'h11223344);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
